// File: rtl/spi_slave_fifo.sv
// SPI slave with RX/TX FIFOs; SCK/CS_L/MOSI are oversampled in i_clk, all four modes, DATA_W-bit words.
// Build macro SPI_FRAME_STAT_EN adds o_frame_done / o_frame_words (per-frame complete word count).
module spi_slave_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter bit CPOL       = 1'b0,
  parameter bit CPHA       = 1'b0,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_MISO  = 1'b1
) (
  input  logic                          i_clk,
  input  logic                          reset,
  input  logic                          i_cs,
  input  logic                          i_we,
  input  logic                          i_re,
  input  logic                          i_clr_err,
  input  logic [DATA_W-1:0]             i_data,
  output logic [DATA_W-1:0]             o_data,
  output logic                          o_rx_valid,
  output logic [$clog2(FIFO_DEPTH):0]   o_rx_level,
  output logic                          o_tx_full,
  output logic [$clog2(FIFO_DEPTH):0]   o_tx_level,
  output logic [2:0]                    o_err,
  output logic                          o_busy,
`ifdef SPI_FRAME_STAT_EN
  output logic                          o_frame_done,
  output logic [15:0]                   o_frame_words,
`endif
  input  logic                          i_spi_sck,
  input  logic                          i_spi_cs_l,
  input  logic                          i_spi_mosi,
  output logic                          o_spi_miso
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_WORD_DONE} state_t;

  logic sck_s1_q, sck_s2_q, sck_h_q;
  logic csl_s1_q, csl_s2_q, csl_h_q;
  logic mosi_s1_q, mosi_s2_q;

  always_ff @(posedge i_clk or posedge reset) begin
    if (reset) begin
      sck_s1_q  <= CPOL;
      sck_s2_q  <= CPOL;
      sck_h_q   <= CPOL;
      csl_s1_q  <= 1'b1;
      csl_s2_q  <= 1'b1;
      csl_h_q   <= 1'b1;
      mosi_s1_q <= 1'b0;
      mosi_s2_q <= 1'b0;
    end else begin
      sck_s1_q  <= i_spi_sck;
      sck_s2_q  <= sck_s1_q;
      sck_h_q   <= sck_s2_q;
      csl_s1_q  <= i_spi_cs_l;
      csl_s2_q  <= csl_s1_q;
      csl_h_q   <= csl_s2_q;
      mosi_s1_q <= i_spi_mosi;
      mosi_s2_q <= mosi_s1_q;
    end
  end

  logic lead_edge, trail_edge, sample_edge, shift_edge, cs_fall, cs_rise;
  assign lead_edge   = (sck_h_q == CPOL) && (sck_s2_q != CPOL);
  assign trail_edge  = (sck_h_q != CPOL) && (sck_s2_q == CPOL);
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign shift_edge  = CPHA ? lead_edge : trail_edge;
  assign cs_fall     = csl_h_q & ~csl_s2_q;
  assign cs_rise     = ~csl_h_q & csl_s2_q;

  // FIFO storage and pointers (one extra wrap bit each)
  logic [DATA_W-1:0] rx_mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0] tx_mem_q [FIFO_DEPTH];
  logic [AW:0]       rx_wr_q, rx_rd_q, tx_wr_q, tx_rd_q;
  logic              rx_empty, rx_full, tx_empty, tx_full;
  logic              rx_push, rx_pop, tx_push, tx_pop;

  assign rx_empty = (rx_wr_q == rx_rd_q);
  assign rx_full  = (rx_wr_q[AW] != rx_rd_q[AW]) && (rx_wr_q[AW-1:0] == rx_rd_q[AW-1:0]);
  assign tx_empty = (tx_wr_q == tx_rd_q);
  assign tx_full  = (tx_wr_q[AW] != tx_rd_q[AW]) && (tx_wr_q[AW-1:0] == tx_rd_q[AW-1:0]);

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
  logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
  logic              miso_q, miso_d;
  logic              tx_load, word_done;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rx_sh_d   = rx_sh_q;
    tx_sh_d   = tx_sh_q;
    tx_load   = 1'b0;
    word_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cs_fall) begin
          tx_load = 1'b1;
          cnt_d   = '0;
          state_d = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (cs_rise) begin
          state_d = S_IDLE;
        end else if (sample_edge) begin
          rx_sh_d = MSB_FIRST ? {rx_sh_q[DATA_W-2:0], mosi_s2_q}
                              : {mosi_s2_q, rx_sh_q[DATA_W-1:1]};
          cnt_d   = cnt_q + CW'(1);
          if (cnt_q == CW'(DATA_W - 1)) state_d = S_WORD_DONE;
        end else if (shift_edge && (cnt_q != '0)) begin
          // A shift edge at count 0 would skip the first bit of a freshly loaded word
          tx_sh_d = MSB_FIRST ? {tx_sh_q[DATA_W-2:0], 1'b1}
                              : {1'b1, tx_sh_q[DATA_W-1:1]};
        end
      end
      S_WORD_DONE: begin
        word_done = 1'b1;
        tx_load   = 1'b1;
        cnt_d     = '0;
        state_d   = cs_rise ? S_IDLE : S_ACTIVE;
      end
      default: state_d = S_IDLE;
    endcase
    if (tx_load) tx_sh_d = tx_empty ? '1 : tx_mem_q[tx_rd_q[AW-1:0]];
    miso_d = (state_q == S_IDLE) ? IDLE_MISO
                                 : (MSB_FIRST ? tx_sh_q[DATA_W-1] : tx_sh_q[0]);
  end

  always_ff @(posedge i_clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rx_sh_q <= '0;
      tx_sh_q <= '0;
      miso_q  <= IDLE_MISO;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rx_sh_q <= rx_sh_d;
      tx_sh_q <= tx_sh_d;
      miso_q  <= miso_d;
    end
  end

  assign rx_push = word_done & ~rx_full;
  assign rx_pop  = i_re & i_cs & ~rx_empty;
  assign tx_push = i_we & i_cs & ~tx_full;
  assign tx_pop  = tx_load & ~tx_empty;

  always_ff @(posedge i_clk) begin
    if (rx_push) rx_mem_q[rx_wr_q[AW-1:0]] <= rx_sh_q;
    if (tx_push) tx_mem_q[tx_wr_q[AW-1:0]] <= i_data;
  end

  always_ff @(posedge i_clk or posedge reset) begin
    if (reset) begin
      rx_wr_q <= '0;
      rx_rd_q <= '0;
      tx_wr_q <= '0;
      tx_rd_q <= '0;
    end else begin
      if (rx_push) rx_wr_q <= rx_wr_q + (AW+1)'(1);
      if (rx_pop)  rx_rd_q <= rx_rd_q + (AW+1)'(1);
      if (tx_push) tx_wr_q <= tx_wr_q + (AW+1)'(1);
      if (tx_pop)  tx_rd_q <= tx_rd_q + (AW+1)'(1);
    end
  end

  // Error events are OR-ed in after the clear so a same-cycle event survives it
  logic [2:0] err_q, err_d;
  always_comb begin
    err_d = (i_clr_err & i_cs) ? 3'b000 : err_q;
    err_d = err_d | {i_we & i_cs & tx_full, tx_load & tx_empty, word_done & rx_full};
  end

  always_ff @(posedge i_clk or posedge reset) begin
    if (reset) err_q <= 3'b000;
    else       err_q <= err_d;
  end

  assign o_data     = rx_empty ? '0 : rx_mem_q[rx_rd_q[AW-1:0]];
  assign o_rx_valid = ~rx_empty;
  assign o_rx_level = rx_wr_q - rx_rd_q;
  assign o_tx_full  = tx_full;
  assign o_tx_level = tx_wr_q - tx_rd_q;
  assign o_err      = err_q;
  assign o_busy     = ~csl_s2_q;
  assign o_spi_miso = miso_q;

`ifdef SPI_FRAME_STAT_EN
  logic        frame_done_q;
  logic [15:0] frame_words_q;

  always_ff @(posedge i_clk or posedge reset) begin
    if (reset) begin
      frame_done_q  <= 1'b0;
      frame_words_q <= '0;
    end else begin
      frame_done_q <= cs_rise;
      if (cs_fall)
        frame_words_q <= '0;
      else if (word_done && (frame_words_q != 16'hFFFF))
        frame_words_q <= frame_words_q + 16'd1;
    end
  end

  assign o_frame_done  = frame_done_q;
  assign o_frame_words = frame_words_q;
`endif

endmodule

// File: tb/tb_spi_slave_fifo.sv
// Bench for spi_slave_fifo: five instances (modes 0-3 MSB-first, mode 0 LSB-first) driven by a
// bit-banged SPI master, checked against a queue-based model plus fixed vectors.
`timescale 1ns/1ps
module tb_spi_slave_fifo;

  localparam int N = 5;
  localparam int H = 4;                       // SCK half period in i_clk cycles (8x oversampling)
  localparam logic [N-1:0] CPOL_V = 5'b01100;
  localparam logic [N-1:0] CPHA_V = 5'b01010;
  localparam logic [N-1:0] MSB_V  = 5'b01111;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       bcs  [N];
  logic       we, re, clr;
  logic [7:0] wdata;
  logic [7:0] rdata [N];
  logic       rxv [N], txf [N], busy [N], miso [N];
  logic [2:0] rxl [N], txl [N], err [N];
  logic       sck [N], csl [N], mosi [N];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    spi_slave_fifo #(
      .DATA_W(8), .FIFO_DEPTH(4), .CPOL(CPOL_V[g]), .CPHA(CPHA_V[g]),
      .MSB_FIRST(MSB_V[g]), .IDLE_MISO(1'b1)
    ) u_dut (
      .i_clk(clk), .reset(rst), .i_cs(bcs[g]), .i_we(we), .i_re(re), .i_clr_err(clr),
      .i_data(wdata), .o_data(rdata[g]), .o_rx_valid(rxv[g]), .o_rx_level(rxl[g]),
      .o_tx_full(txf[g]), .o_tx_level(txl[g]), .o_err(err[g]), .o_busy(busy[g]),
      .i_spi_sck(sck[g]), .i_spi_cs_l(csl[g]), .i_spi_mosi(mosi[g]), .o_spi_miso(miso[g])
    );
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: FIFO contents as queues, sticky error bits
  logic [7:0] m_rx [$];
  logic [7:0] m_tx [$];
  logic [2:0] m_err;

  task automatic m_load(output logic [7:0] w);
    if (m_tx.size() == 0) begin
      w = 8'hFF;
      m_err[1] = 1'b1;
    end else begin
      w = m_tx.pop_front();
    end
  endtask

  task automatic check_state(input int k);
    chk("rx_level", 32'(rxl[k]), m_rx.size());
    chk("tx_level", 32'(txl[k]), m_tx.size());
    chk("rx_valid", 32'(rxv[k]), 32'(m_rx.size() != 0));
    chk("tx_full", 32'(txf[k]), 32'(m_tx.size() == 4));
    chk("err", 32'(err[k]), 32'(m_err));
    chk("rx_head", 32'(rdata[k]), (m_rx.size() != 0) ? 32'(m_rx[0]) : 32'd0);
    chk("miso_idle", 32'(miso[k]), 32'd1);
    chk("busy_idle", 32'(busy[k]), 32'd0);
  endtask

  task automatic do_reset();
    for (int k = 0; k < N; k++) begin
      sck[k] = CPOL_V[k]; csl[k] = 1'b1; mosi[k] = 1'b0; bcs[k] = 1'b0;
    end
    we = 1'b0; re = 1'b0; clr = 1'b0; wdata = 8'h00;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    m_rx.delete(); m_tx.delete(); m_err = 3'b000;
  endtask

  task automatic host_write(input int k, input logic [7:0] d);
    bcs[k] = 1'b1; we = 1'b1; wdata = d;
    @(negedge clk);
    bcs[k] = 1'b0; we = 1'b0;
    if (m_tx.size() == 4) m_err[2] = 1'b1;
    else m_tx.push_back(d);
  endtask

  task automatic host_read(input int k);
    chk("rd_data", 32'(rdata[k]), (m_rx.size() != 0) ? 32'(m_rx[0]) : 32'd0);
    bcs[k] = 1'b1; re = 1'b1;
    @(negedge clk);
    bcs[k] = 1'b0; re = 1'b0;
    if (m_rx.size() != 0) void'(m_rx.pop_front());
  endtask

  task automatic host_clr(input int k);
    bcs[k] = 1'b1; clr = 1'b1;
    @(negedge clk);
    bcs[k] = 1'b0; clr = 1'b0;
    m_err = 3'b000;
  endtask

  logic [7:0] f_mosi [8];
  logic [7:0] f_miso [8];

  // SPI master: last word carries last_bits bits, then CS is released
  task automatic spi_frame(input int k, input int nw, input int last_bits);
    logic pol, pha, msb;
    int   nb, pos;
    pol = CPOL_V[k]; pha = CPHA_V[k]; msb = MSB_V[k];
    sck[k] = pol;
    csl[k] = 1'b0;
    repeat (6) @(negedge clk);
    for (int w = 0; w < nw; w++) begin
      nb = (w == nw - 1) ? last_bits : 8;
      f_miso[w] = 8'h00;
      for (int b = 0; b < nb; b++) begin
        pos = msb ? 7 - b : b;
        if (!pha) begin
          mosi[k] = f_mosi[w][pos];
          repeat (H) @(negedge clk);
          f_miso[w][pos] = miso[k];
          sck[k] = ~pol;
          repeat (H) @(negedge clk);
          sck[k] = pol;
        end else begin
          repeat (H) @(negedge clk);
          sck[k] = ~pol;
          mosi[k] = f_mosi[w][pos];
          repeat (H) @(negedge clk);
          f_miso[w][pos] = miso[k];
          sck[k] = pol;
        end
      end
    end
    repeat (H) @(negedge clk);
    csl[k] = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  // Every complete word triggers one more TX load (for the following word)
  task automatic run_frame(input int k, input int nw, input int last_bits);
    logic [7:0] exp_tx [9];
    int ncomp;
    ncomp = (last_bits == 8) ? nw : nw - 1;
    for (int i = 0; i <= ncomp; i++) m_load(exp_tx[i]);
    spi_frame(k, nw, last_bits);
    for (int i = 0; i < ncomp; i++) begin
      chk("miso_word", 32'(f_miso[i]), 32'(exp_tx[i]));
      if (m_rx.size() == 4) m_err[0] = 1'b1;
      else m_rx.push_back(f_mosi[i]);
    end
    check_state(k);
  endtask

  typedef struct {
    int         k;
    logic [7:0] tx;
    logic [7:0] mo;
    logic [7:0] exp_rx;
    logic [7:0] exp_miso;
  } vec_t;
  vec_t vt [5];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int op, nw;
    vt[0] = '{0, 8'hA5, 8'h3C, 8'h3C, 8'hA5};
    vt[1] = '{1, 8'h7E, 8'h81, 8'h81, 8'h7E};
    vt[2] = '{2, 8'h7E, 8'h81, 8'h81, 8'h7E};
    vt[3] = '{3, 8'h7E, 8'h81, 8'h81, 8'h7E};
    vt[4] = '{4, 8'h7E, 8'h81, 8'h81, 8'h7E};

    for (int k = 0; k < N; k++) begin
      sck[k] = CPOL_V[k]; csl[k] = 1'b1; mosi[k] = 1'b0; bcs[k] = 1'b0;
    end
    we = 1'b0; re = 1'b0; clr = 1'b0; wdata = 8'h00;
    #12;
    for (int k = 0; k < N; k++) begin
      chk("rst_rx_level", 32'(rxl[k]), 0);
      chk("rst_tx_level", 32'(txl[k]), 0);
      chk("rst_err", 32'(err[k]), 0);
      chk("rst_miso", 32'(miso[k]), 1);
      chk("rst_data", 32'(rdata[k]), 0);
    end
    do_reset();

    // Single-word frames in each configuration, fixed expectations
    for (int i = 0; i < 5; i++) begin
      do_reset();
      host_write(vt[i].k, vt[i].tx);
      f_mosi[0] = vt[i].mo;
      run_frame(vt[i].k, 1, 8);
      chk("vec_miso", 32'(f_miso[0]), 32'(vt[i].exp_miso));
      chk("vec_rx", 32'(rdata[vt[i].k]), 32'(vt[i].exp_rx));
      chk("vec_rx_valid", 32'(rxv[vt[i].k]), 1);
      chk("vec_rx_level", 32'(rxl[vt[i].k]), 1);
    end

    // TX underflow over a two-word frame, then clear
    do_reset();
    f_mosi[0] = 8'h11; f_mosi[1] = 8'h22;
    run_frame(0, 2, 8);
    chk("uf_miso0", 32'(f_miso[0]), 32'hFF);
    chk("uf_miso1", 32'(f_miso[1]), 32'hFF);
    chk("uf_err1", 32'(err[0][1]), 1);
    host_clr(0);
    chk("uf_clr", 32'(err[0]), 0);

    // RX overflow: fifth word dropped, head keeps the first
    do_reset();
    for (int i = 0; i < 5; i++) begin
      f_mosi[0] = 8'h10 + 8'(i);
      run_frame(0, 1, 8);
      chk("ov_level", 32'(rxl[0]), (i < 4) ? i + 1 : 4);
      chk("ov_err0", 32'(err[0][0]), (i < 4) ? 0 : 1);
    end
    chk("ov_head", 32'(rdata[0]), 32'h10);

    // Aborted word followed by a clean frame
    do_reset();
    host_write(0, 8'h01); host_write(0, 8'h02); host_write(0, 8'h03);
    f_mosi[0] = 8'hF0;
    run_frame(0, 1, 5);
    chk("ab_level0", 32'(rxl[0]), 0);
    f_mosi[0] = 8'h55;
    run_frame(0, 1, 8);
    chk("ab_data", 32'(rdata[0]), 32'h55);
    chk("ab_level", 32'(rxl[0]), 1);
    chk("ab_err", 32'(err[0]), 0);

    // Write while full, read while empty
    do_reset();
    for (int i = 0; i < 5; i++) host_write(0, 8'hC0 + 8'(i));
    check_state(0);
    chk("wf_err2", 32'(err[0][2]), 1);
    host_read(0);
    check_state(0);

    // Reset asserted in the middle of a word
    do_reset();
    f_mosi[0] = 8'h42;
    run_frame(0, 1, 8);
    host_write(0, 8'hAA); host_write(0, 8'hBB);
    csl[0] = 1'b0;
    repeat (6) @(negedge clk);
    for (int b = 0; b < 3; b++) begin
      mosi[0] = b[0];
      repeat (H) @(negedge clk);
      sck[0] = 1'b1;
      repeat (H) @(negedge clk);
      sck[0] = 1'b0;
    end
    chk("mr_busy", 32'(busy[0]), 1);
    chk("mr_tx_level", 32'(txl[0]), 1);
    chk("mr_rx_level", 32'(rxl[0]), 1);
    #2 rst = 1'b1;
    #1;
    chk("mr_rx_level_rst", 32'(rxl[0]), 0);
    chk("mr_tx_level_rst", 32'(txl[0]), 0);
    chk("mr_err_rst", 32'(err[0]), 0);
    chk("mr_busy_rst", 32'(busy[0]), 0);
    chk("mr_miso_rst", 32'(miso[0]), 1);
    chk("mr_data_rst", 32'(rdata[0]), 0);
    chk("mr_valid_rst", 32'(rxv[0]), 0);
    csl[0] = 1'b1;
    @(negedge clk);
    do_reset();
    host_write(0, 8'h5A);
    f_mosi[0] = 8'hC3;
    run_frame(0, 1, 8);
    chk("mr_after", 32'(rdata[0]), 32'hC3);

    // Randomised host/SPI traffic against the model, every configuration
    for (int k = 0; k < N; k++) begin
      do_reset();
      for (int it = 0; it < 14; it++) begin
        op = $urandom_range(0, 4);
        case (op)
          0, 1: host_write(k, 8'($urandom));
          2:    host_read(k);
          3: begin
            nw = $urandom_range(1, 3);
            for (int i = 0; i < nw; i++) f_mosi[i] = 8'($urandom);
            run_frame(k, nw, 8);
          end
          default: host_clr(k);
        endcase
        check_state(k);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_slave_fifo.md
Name: spi_slave_fifo

Overview:
Parametrised successor to the single-register SPI slave. All SPI inputs are oversampled in the i_clk domain, so there is no logic clocked by SCK. The block supports all four SPI modes and configurable word width. RX and TX FIFOs decouple the host bus from SPI timing. It sits between the external SPI master (MCU) and the VGA text controller register/command bus.

Parameters:
DATA_W, 8, SPI word width in bits (4..32)
FIFO_DEPTH, 4, entries per RX and TX FIFO; power of 2, >=2
CPOL, 0, SCK idle level
CPHA, 0, 0 = sample on leading edge; 1 = sample on trailing edge
MSB_FIRST, 1, 1 = MSB shifted first; 0 = LSB first
IDLE_MISO, 1, MISO level while CS is inactive

Ports:
i_clk  in  1  system clock; must be >= 4x SCK frequency
reset  in  1  asynchronous, active-high
i_cs  in  1  bus select for this block
i_we  in  1  push i_data to TX FIFO (qualified by i_cs)
i_re  in  1  pop RX FIFO head (qualified by i_cs)
i_clr_err  in  1  clear sticky error bits (qualified by i_cs)
i_data  in  DATA_W  TX write data
o_data  out  DATA_W  RX FIFO head (first-word fall-through)
o_rx_valid  out  1  RX FIFO not empty
o_rx_level  out  $clog2(FIFO_DEPTH)+1  RX occupancy
o_tx_full  out  1  TX FIFO full
o_tx_level  out  $clog2(FIFO_DEPTH)+1  TX occupancy
o_err  out  3  sticky: [0] RX overflow, [1] TX underflow, [2] TX write-while-full
o_busy  out  1  synchronised CS active
i_spi_sck  in  1  SPI clock
i_spi_cs_l  in  1  SPI chip select, active-low
i_spi_mosi  in  1  SPI data in
o_spi_miso  out  1  SPI data out (registered)

Behaviour:
- Reset (async) values: FIFOs empty, levels 0, o_rx_valid 0, o_tx_full 0, o_err 0, o_busy 0, o_data 0, o_spi_miso = IDLE_MISO, bit counter 0. Synchronisers are preset to the idle levels: SCK = CPOL, CS_L = 1.
- Synchronisation: SCK, CS_L and MOSI each pass through a 2-FF synchroniser, plus one history FF for edge detection. Edge-detect latency is 3 i_clk.
- Leading edge = SCK leaving CPOL; trailing edge = SCK returning to CPOL.
  - Sample edge: leading if CPHA=0, trailing if CPHA=1.
  - Shift edge: the other edge.
- State machine:
  - IDLE: MISO = IDLE_MISO. On synced CS falling edge, load TX word and go to ACTIVE.
  - ACTIVE: on each sample edge, shift MOSI into the RX shift register and increment the bit counter. On each shift edge, advance the TX shift register and update MISO.
    - CPHA=1: skip the first shift edge of each word, because bit 0 is already presented at load time.
  - WORD_DONE: one i_clk. Entered on the DATA_W-th sample.
    - Push RX word; if RX FIFO is full, drop the word and set o_err[0].
    - Reload TX shift register for the next word; bit counter wraps to 0.
    - Return to ACTIVE.
  - On synced CS rising edge (any state except IDLE), go to IDLE. A partial RX word is discarded (no push, no error). A partially sent TX word is lost.
- TX load: pop the TX FIFO head. If the TX FIFO is empty, load all-ones and set o_err[1].
  - MISO shows the first bit one i_clk after load.
  - The master must allow >= 4 i_clk between CS fall and the first SCK edge.
- Bit order: MSB_FIRST selects bit DATA_W-1 or bit 0 as first out and first in.
- Host bus:
  - Push when i_we & i_cs & !full. Write while full is ignored and sets o_err[2].
  - Pop when i_re & i_cs & o_rx_valid. Read while empty: no change, no error.
  - Same-cycle push and pop on one FIFO: both occur, level unchanged.
  - An SPI push/pop and a bus pop/push on the same FIFO in the same cycle are both honoured.
- Errors: i_clr_err & i_cs clears o_err. An error event in the same cycle wins over the clear.
- Pointers are $clog2(FIFO_DEPTH)+1 bits and wrap naturally. Full = MSB differs and low bits equal.

Optional Feature:
SPI_FRAME_STAT_EN
- Defined: adds output o_frame_done (1-cycle pulse on synced CS rising edge) and output o_frame_words (16 bits). o_frame_words counts complete words received in the last frame, saturates at 16'hFFFF, and is held until the next CS fall clears it.
- Undefined: neither port exists; no counter logic.

Test Plan:
1. Mode 0, DATA_W=8. Host writes 8'hA5, master sends 8'h3C with 64 MHz i_clk / 8 MHz SCK -> master reads 8'hA5, o_data = 8'h3C, o_rx_valid = 1, o_rx_level = 1.
2. Modes 1, 2, 3 and MSB_FIRST=0, one frame each with MOSI 8'h81 and TX 8'h7E -> bit-exact in both directions for each configuration.
3. TX FIFO empty at CS fall, 2-word frame -> MISO sends 8'hFF twice and o_err[1] = 1. i_clr_err then clears it -> o_err = 3'b000.
4. 5 words received with FIFO_DEPTH=4 and no reads -> levels 1..4, 5th word dropped, o_err[0] = 1, head still the first word.
5. CS deasserted after 5 of 8 bits, then a full frame of 8'h55 -> only 8'h55 appears in the RX FIFO, no error, FSM back in IDLE.
6. Assert reset mid-word -> all outputs return to reset values immediately. The next frame after reset is received correctly.
